// File: rtl/uart_rx_pkg.sv
// Shared definitions for the bus-sniffer serial receive stages: receiver FSM
// encoding and the default bit timing / word size.
package uart_rx_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;
  localparam int unsigned DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  // Delay from the start edge to the middle of the start bit.
  function automatic int unsigned half_bit_clks(input int unsigned clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Loadable down-counter used to time serial bit periods; tick marks the
// cycle in which the loaded interval expires.
module uart_rx_bit_timer #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops sample their inputs from the same pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// Asynchronous serial receiver: recovers start/data/stop frames from a
// synchronized line and hands words to a single-entry valid/ack holder.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 out_valid,
  input  logic                 out_ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  // Timer reloads are one less than the interval because tick fires at zero.
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(half_bit_clks(CLKS_PER_BIT) - 1);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT    = IDX_W'(DATA_BITS - 1);

  rx_state_e state_d, state_q;

  logic                 rx_prev_d, rx_prev_q;
  logic [IDX_W-1:0]     bit_idx_d, bit_idx_q;
  logic [DATA_BITS-1:0] shift_d, shift_q;
  logic [DATA_BITS-1:0] data_d, data_q;
  logic                 valid_d, valid_q;
  logic                 frame_err_d, frame_err_q;
  logic                 overrun_d, overrun_q;

  logic             timer_en;
  logic             timer_load;
  logic [CNT_W-1:0] timer_load_val;
  logic             tick;
  logic             stop_ok;
  logic             stop_bad;

  assign timer_en = (state_q == RX_START) || (state_q == RX_DATA) || (state_q == RX_STOP);

  uart_rx_bit_timer #(
    .WIDTH (CNT_W)
  ) u_bit_timer (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .en       (timer_en),
    .load     (timer_load),
    .load_val (timer_load_val),
    .tick     (tick)
  );

  assign rx_prev_d = rx_line;

  always_comb begin
    state_d        = state_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    timer_load     = 1'b0;
    timer_load_val = BIT_RELOAD;
    stop_ok        = 1'b0;
    stop_bad       = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        if (!rx_line && rx_prev_q) begin
          state_d        = RX_START;
          timer_load     = 1'b1;
          timer_load_val = HALF_RELOAD;
        end
      end

      RX_START: begin
        if (tick) begin
          // A line back high mid start bit is a glitch, dropped silently.
          if (!rx_line) begin
            state_d    = RX_DATA;
            timer_load = 1'b1;
            bit_idx_d  = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end

      RX_DATA: begin
        if (tick) begin
          shift_d    = {rx_line, shift_q[DATA_BITS-1:1]};
          timer_load = 1'b1;
          if (bit_idx_q == LAST_BIT) begin
            state_d   = RX_STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end

      RX_STOP: begin
        if (tick) begin
          if (rx_line) begin
            stop_ok = 1'b1;
            state_d = RX_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = RX_WAIT_IDLE;
          end
        end
      end

      RX_WAIT_IDLE: begin
        // Holding here keeps a break condition from looking like new starts.
        if (rx_line) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = stop_bad;
    overrun_d   = 1'b0;

    if (stop_ok) begin
      // An ack in the delivery cycle frees the slot for the new word.
      if (!valid_q || out_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= RX_IDLE;
      rx_prev_q   <= 1'b1;
      bit_idx_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_prev_q   <= rx_prev_d;
      bit_idx_q   <= bit_idx_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: the shift register has no reset; every bit is rewritten by the
  // data phase before its contents can reach the holder.
  always_ff @(posedge sys_clk) begin
    shift_q <= shift_d;
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with N=16, D=8: a scoreboard queue holds the
// words expected on the holder, and event timing is compared cycle-exactly.
module tb_uart_rx;

  localparam int N = 16;
  localparam int D = 8;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         rx_line;
  logic         out_ack;
  logic [D-1:0] data_out;
  logic         out_valid;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [D-1:0] sb[$];

  int busy_rise_cyc = -1;
  int busy_fall_cyc = -1;
  int busy_rise_cnt = 0;
  int fe_cnt = 0;
  int fe_cyc = -1;
  int ov_cnt = 0;
  int ov_cyc = -1;
  int dlv_cnt = 0;
  int dlv_cyc = -1;

  logic         prev_valid = 1'b0;
  logic         prev_busy  = 1'b0;
  logic [D-1:0] prev_data  = '0;

  uart_rx #(
    .CLKS_PER_BIT (N),
    .DATA_BITS    (D)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .rx_line   (rx_line),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: sampled mid-cycle, records event cycles and pops the
  // scoreboard whenever a new word lands in the holder.
  always @(negedge sys_clk) begin
    logic [D-1:0] exp_word;
    if (busy === 1'b1 && prev_busy === 1'b0) begin
      busy_rise_cyc = cyc;
      busy_rise_cnt++;
    end
    if (busy === 1'b0 && prev_busy === 1'b1) busy_fall_cyc = cyc;
    if (frame_err === 1'b1) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (overrun === 1'b1) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
    if (out_valid === 1'b1 && (prev_valid !== 1'b1 || data_out !== prev_data)) begin
      dlv_cnt++;
      dlv_cyc = cyc;
      check("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_word = sb.pop_front();
        check("sb_word", data_out, exp_word);
      end
    end
    prev_valid = out_valid;
    prev_busy  = busy;
    prev_data  = data_out;
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_line = b;
    step(n);
  endtask

  // Drives start, D data bits LSB first and the stop bit, N cycles each.
  task automatic send_frame(input logic [D-1:0] d, input logic stop_b);
    drive_bit(1'b0, N);
    for (int k = 0; k < D; k++) drive_bit(d[k], N);
    drive_bit(stop_b, N);
  endtask

  initial begin
    int t;
    int t2;
    int fe0;
    int ov0;
    int d0;
    int br0;

    rx_line = 1'b1;
    out_ack = 1'b0;
    sys_rst = 1'b1;
    step(4);
    check("rst_data_out", data_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    sys_rst = 1'b0;
    step(4);

    // Clean frame 0xA5.
    fe0 = fe_cnt; ov0 = ov_cnt;
    t = cyc;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    check("a5_dlv_cycle", dlv_cyc, t + 153);
    check("a5_valid", out_valid, 1);
    check("a5_data", data_out, 8'hA5);
    check("a5_busy_rise", busy_rise_cyc, t + 1);
    check("a5_busy_fall", busy_fall_cyc, t + 153);
    check("a5_no_frame_err", fe_cnt - fe0, 0);
    check("a5_no_overrun", ov_cnt - ov0, 0);
    out_ack = 1'b1;
    step(1);
    out_ack = 1'b0;
    check("ack_clears_valid", out_valid, 0);
    check("ack_keeps_data", data_out, 8'hA5);

    // Three-cycle low glitch, then 0x5A starting in the first IDLE cycle.
    step(5);
    fe0 = fe_cnt; ov0 = ov_cnt; d0 = dlv_cnt;
    t = cyc;
    drive_bit(1'b0, 3);
    rx_line = 1'b1;
    step(5);
    check("glitch_busy_t8", busy, 1);
    step(1);
    check("glitch_busy_fall_t9", busy, 0);
    check("glitch_no_valid", out_valid, 0);
    t2 = cyc;
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    check("5a_dlv_cycle", dlv_cyc, t2 + 153);
    check("5a_single_word", dlv_cnt - d0, 1);
    check("glitch_no_frame_err", fe_cnt - fe0, 0);
    check("glitch_no_overrun", ov_cnt - ov0, 0);
    out_ack = 1'b1;
    step(1);
    out_ack = 1'b0;

    // 0x3C with a low stop bit, line held low 40 more cycles.
    step(5);
    fe0 = fe_cnt; d0 = dlv_cnt; br0 = busy_rise_cnt;
    t = cyc;
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b0, 40);
    rx_line = 1'b1;
    step(3);
    check("ferr_count", fe_cnt - fe0, 1);
    check("ferr_cycle", fe_cyc, t + 153);
    check("ferr_no_valid", out_valid, 0);
    check("ferr_no_word", dlv_cnt - d0, 0);
    check("ferr_busy_fall", busy_fall_cyc, t + 201);
    check("ferr_no_retrigger", busy_rise_cnt - br0, 1);

    // Back-to-back 0x01 then 0xFF with no ack: second word overruns.
    step(5);
    ov0 = ov_cnt;
    t = cyc;
    sb.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    t2 = cyc;
    send_frame(8'hFF, 1'b1);
    check("ovr_first_dlv_cycle", dlv_cyc, t + 153);
    check("ovr_count", ov_cnt - ov0, 1);
    check("ovr_cycle", ov_cyc, t2 + 153);
    check("ovr_data_kept", data_out, 8'h01);
    check("ovr_valid_kept", out_valid, 1);
    out_ack = 1'b1;
    step(1);
    out_ack = 1'b0;
    check("ovr_ack_clears", out_valid, 0);

    // Ack in the delivery cycle of 0x7E while 0x11 is held.
    step(5);
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    step(2);
    ov0 = ov_cnt;
    t = cyc;
    sb.push_back(8'h7E);
    fork
      send_frame(8'h7E, 1'b1);
      begin
        step(152);
        out_ack = 1'b1;
        step(1);
        out_ack = 1'b0;
      end
    join
    check("ackdlv_cycle", dlv_cyc, t + 153);
    check("ackdlv_data", data_out, 8'h7E);
    check("ackdlv_valid", out_valid, 1);
    check("ackdlv_no_overrun", ov_cnt - ov0, 0);

    // Reset mid data bit 4 of 0xC3 while 0x7E is still held.
    step(5);
    fe0 = fe_cnt; ov0 = ov_cnt;
    drive_bit(1'b0, N);
    drive_bit(1'b1, N);
    drive_bit(1'b1, N);
    drive_bit(1'b0, N);
    drive_bit(1'b0, N);
    drive_bit(1'b0, 8);
    check("midrst_busy_before", busy, 1);
    sys_rst = 1'b1;
    step(1);
    sys_rst = 1'b0;
    rx_line = 1'b1;
    check("midrst_data_out", data_out, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_busy", busy, 0);
    d0 = dlv_cnt;
    step(60);
    check("midrst_idle", busy, 0);
    check("midrst_no_word", dlv_cnt - d0, 0);
    check("midrst_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    t = cyc;
    sb.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    check("96_dlv_cycle", dlv_cyc, t + 153);
    check("96_data", data_out, 8'h96);

    step(4);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive stage directly downstream of the input synchronizer. It consumes one already-synchronized line and recovers 8N1-style asynchronous frames by counting `sys_clk` cycles. Each received word is presented on a single-entry valid/ack holding register to the MITM forwarding logic. It also reports framing errors and overruns.

## Interface
- `CLKS_PER_BIT`, 104: `sys_clk` cycles per serial bit (N); must be ≥ 4.
- `DATA_BITS`, 8: data bits per frame (D), range 5..9.
- `sys_clk`  in  1  system clock, sole clock.
- `sys_rst`  in  1  synchronous, active-high reset.
- `rx_line`  in  1  serial line, already synchronized to `sys_clk`; idle high.
- `data_out`  out  DATA_BITS  received word; LSB received first.
- `out_valid`  out  1  `data_out` holds an unconsumed word.
- `out_ack`  in  1  consumer takes the word; effective only while `out_valid`=1.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a word completed while the holder was full; that word is dropped.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Edge detect: `rx_prev` register. Start condition occurs in cycle t when `rx_line`=0 and `rx_prev`=1, in IDLE only.
- FSM states:
  - IDLE: on start condition, go to START with counter cleared.
  - START: wait H = floor(N/2) cycles, then sample. If 0, go to DATA. If 1, treat it as a glitch and go to IDLE with nothing reported.
  - DATA: every N cycles, sample one bit into a shift register, LSB first. After D bits, go to STOP.
  - STOP: after N cycles, sample. If 1, deliver the word and go to IDLE. If 0, pulse `frame_err`, discard the word and go to WAIT_IDLE.
  - WAIT_IDLE: remain until `rx_line`=1, then go to IDLE. This prevents a held-low line (break) from retriggering.
- Delivery rules:
  - Holder empty: load `data_out` and set `out_valid`.
  - Holder full, `out_ack`=0 that cycle: pulse `overrun`; `data_out` and `out_valid` are unchanged.
  - Holder full, `out_ack`=1 that same cycle: load the new word; `out_valid` stays 1; no overrun.
- `out_ack` with `out_valid`=1 and no delivery clears `out_valid` next cycle; `data_out` keeps its last value.
- `out_ack` while `out_valid`=0 is ignored.
- Widths:
  - Cycle counter is $clog2(N) bits and never exceeds N−1.
  - Bit index is $clog2(D+1) bits.
  - No arithmetic wraps silently.

## Timing
- Reset values:
  - `data_out`=0, `out_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - FSM in IDLE.
  - `rx_prev`=1, so a line held low through reset release does not start a frame.
- Sample instants, with the start condition in cycle t:
  - Start bit at t+H.
  - Data bit k (k=0..D−1) at t+H+(k+1)·N.
  - Stop bit at t+H+(D+1)·N.
- `out_valid`/`data_out` update, `frame_err` and `overrun` all occur in the cycle after the stop sample, i.e. registered at t+H+(D+1)·N+1.
- `busy` rises at t+1 and falls one cycle after leaving STOP or WAIT_IDLE.
- A new start condition is accepted from the first IDLE cycle, which allows back-to-back frames with a one-bit stop.
- `sys_rst` mid-frame aborts immediately with no pulses and returns all outputs to reset values, including discarding a held word.

## Structure
- Shared package/header holds the FSM state encoding (IDLE, START, DATA, STOP, WAIT_IDLE) and the default N/D constants used by the other bus-sniffer stages.
- One natural sub-module: `bit_timer`. It is a loadable down-counter that takes the H or N reload and emits a `tick` when it expires. `uart_rx` owns the FSM, shift register and holder.

## Test plan
All scenarios use N=16, D=8, H=8.
- Frame 0xA5 with stop=1, start condition at t: `data_out`=0xA5 and `out_valid`=1 at t+153. `busy` is high from t+1 to t+152, and no error pulses occur.
- Low glitch lasting 3 cycles: no `out_valid`, `frame_err` or `overrun`. `busy` falls at t+9, and a correct frame 0x5A immediately after is received.
- Frame 0x3C with stop bit 0 and the line then held low 40 cycles: one `frame_err` pulse at t+153 and `out_valid` stays 0. `busy` remains high until one cycle after the line returns high, with no retrigger during the low period.
- Frames 0x01 then 0xFF back-to-back, no ack: `data_out`=0x01 with `out_valid`=1, then one `overrun` pulse at the end of the second frame with `data_out` still 0x01. A subsequent `out_ack` clears `out_valid` next cycle.
- `out_ack` asserted exactly in the delivery cycle of a second frame 0x7E while 0x11 is held: `data_out`=0x7E, `out_valid` stays 1, no `overrun`.
- `sys_rst` pulsed during data bit 4 of frame 0xC3: all outputs return to 0 the next cycle. The remaining bits do not produce a word, and a following 0x96 frame is received correctly.
